// File: rtl/cpu_divide_ctrl.sv
// ============================================================================
//  Module   : cpu_divide_ctrl
//  Brief    : Execute-stage sequencer for the iterative 32-bit divider.
//             Registers a DIVU/DIVS/MODU/MODS request, pulses the divider
//             start, waits for done and holds the selected result on a
//             valid/ready writeback port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_divide_ctrl #(
    parameter int DEST_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    // execute-stage request
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [31:0]       req_a,
    input  logic [31:0]       req_b,
    input  logic [DEST_W-1:0] req_dest,
    input  logic              flush,
    output logic              busy,
    // divider interface
    output logic              div_start,
    output logic [31:0]       div_a,
    output logic [31:0]       div_b,
    output logic              div_signed,
    input  logic [31:0]       div_quotient,
    input  logic [31:0]       div_remainder,
    input  logic              div_done,
    // writeback
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DEST_W-1:0] wb_dest,
    output logic [31:0]       wb_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_sel_mod;
    logic                r_div_signed;
    logic [31:0]         r_div_a;
    logic [31:0]         r_div_b;
    logic [31:0]         r_wb_data;
    logic [DEST_W-1:0]   r_wb_dest;

    logic                w_accept;
    logic                w_capture;

    assign w_accept  = req_valid && (r_state == IDLE) && !flush;
    // done is only trusted from WAIT onward; in START it still shows the previous op
    assign w_capture = (r_state == WAIT) && div_done && !flush;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_next_state = START;
            START:                  w_next_state = WAIT;
            WAIT:    if (div_done)  w_next_state = RESULT;
            RESULT:  if (wb_ready)  w_next_state = IDLE;
            default:                w_next_state = IDLE;
        endcase
        if (flush) begin
            w_next_state = IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div_a      <= 32'd0;
            r_div_b      <= 32'd0;
            r_div_signed <= 1'b0;
            r_sel_mod    <= 1'b0;
            r_wb_dest    <= '0;
            r_wb_data    <= 32'd0;
        end else begin
            if (w_accept) begin
                r_div_a      <= req_a;
                r_div_b      <= req_b;
                r_div_signed <= req_op[0];
                r_sel_mod    <= req_op[1];
                r_wb_dest    <= req_dest;
            end
            if (w_capture) begin
                r_wb_data <= r_sel_mod ? div_remainder : div_quotient;
            end
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign div_start  = (r_state == START);
    assign wb_valid   = (r_state == RESULT);
    assign div_a      = r_div_a;
    assign div_b      = r_div_b;
    assign div_signed = r_div_signed;
    assign wb_dest    = r_wb_dest;
    assign wb_data    = r_wb_data;

endmodule

`default_nettype wire

// File: tb/tb_cpu_divide_ctrl.sv
// ============================================================================
//  Module   : tb_cpu_divide_ctrl
//  Brief    : Scoreboard bench for cpu_divide_ctrl with a behavioural divider.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_divide_ctrl;

    localparam logic [1:0] C_DIVU = 2'b00;
    localparam logic [1:0] C_DIVS = 2'b01;
    localparam logic [1:0] C_MODU = 2'b10;
    localparam logic [1:0] C_MODS = 2'b11;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_dest;
    logic        flush;
    logic        busy;
    logic        div_start;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_signed;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_done;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;

    cpu_divide_ctrl #(.DEST_W(5)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_dest      (req_dest),
        .flush         (flush),
        .busy          (busy),
        .div_start     (div_start),
        .div_a         (div_a),
        .div_b         (div_b),
        .div_signed    (div_signed),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_done      (div_done),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_dest       (wb_dest),
        .wb_data       (wb_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Behavioural divider: 32-step latency, one-step for b==0 or repeated operands.
    logic [31:0] m_pend_q, m_pend_r, m_last_a, m_last_b;
    logic        m_last_s = 1'b0;
    logic        m_have_last = 1'b0;
    int          m_cnt = 0;

    initial begin
        div_done      = 1'b0;
        div_quotient  = 32'd0;
        div_remainder = 32'd0;
    end

    function automatic logic [63:0] divide(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] ma, mb, uq, ur, q, r;
        logic        na, nb;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        na = s & a[31];
        nb = s & b[31];
        ma = na ? (~a + 32'd1) : a;
        mb = nb ? (~b + 32'd1) : b;
        uq = ma / mb;
        ur = ma % mb;
        q  = (na ^ nb) ? (~uq + 32'd1) : uq;
        r  = na ? (~ur + 32'd1) : ur;
        return {q, r};
    endfunction

    always @(posedge clock) begin
        if (div_start) begin
            logic [63:0] res;
            res = divide(div_a, div_b, div_signed);
            if (div_b == 32'd0 ||
                (m_have_last && div_a == m_last_a && div_b == m_last_b && div_signed == m_last_s)) begin
                div_quotient  <= res[63:32];
                div_remainder <= res[31:0];
                div_done      <= 1'b1;
                m_cnt         <= 0;
            end else begin
                m_pend_q <= res[63:32];
                m_pend_r <= res[31:0];
                div_done <= 1'b0;
                m_cnt    <= 32;
            end
            m_last_a    <= div_a;
            m_last_b    <= div_b;
            m_last_s    <= div_signed;
            m_have_last <= 1'b1;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                div_done      <= 1'b1;
                div_quotient  <= m_pend_q;
                div_remainder <= m_pend_r;
            end
        end
    end

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
        int unsigned vcyc;
    } exp_t;

    exp_t        sb[$];
    int          start_cnt = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] held_data;
    logic [4:0]  held_dest;

    // Monitor: pops the scoreboard on every writeback handshake.
    always @(negedge clock) begin
        if (div_start) start_cnt++;
        check("ready_vs_busy", {31'd0, req_ready}, {31'd0, !busy});
        if (wb_valid) begin
            if (!prev_valid) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_wb: got wb_valid=1 data %h expected no result", wb_data);
                end else begin
                    check("wb_latency", cyc, sb[0].vcyc);
                end
                held_data = wb_data;
                held_dest = wb_dest;
            end else begin
                check("wb_data_stable", wb_data, held_data);
                check("wb_dest_stable", {27'd0, wb_dest}, {27'd0, held_dest});
            end
            if (wb_ready && sb.size() != 0) begin
                check("wb_data", wb_data, sb[0].data);
                check("wb_dest", {27'd0, wb_dest}, {27'd0, sb[0].dest});
                void'(sb.pop_front());
            end
        end
        prev_valid = wb_valid;
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dest, input logic [31:0] want, input int lat,
                         input bit expect_wb, output int unsigned t);
        bit accepted;
        int n;
        exp_t e;
        @(posedge clock);
        #1;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_dest  = dest;
        accepted  = 1'b0;
        n         = 0;
        t         = 0;
        while (!accepted && n < 200) begin
            @(negedge clock);
            if (req_ready && !flush) accepted = 1'b1;
            else n++;
        end
        if (!accepted) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            t = cyc;
            if (expect_wb) begin
                e.dest = dest;
                e.data = want;
                e.vcyc = t + lat;
                sb.push_back(e);
            end
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int unsigned target);
        while (cyc < target) @(negedge clock);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (n >= 500) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int unsigned t;
        int          n;
        int          s0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = 32'd0;
        req_b     = 32'd0;
        req_dest  = 5'd0;
        flush     = 1'b0;
        wb_ready  = 1'b1;

        repeat (2) @(negedge clock);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_div_start", {31'd0, div_start}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_div_a", div_a, 32'd0);
        check("rst_div_b", div_b, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_dest", {27'd0, wb_dest}, 32'd0);
        check("rst_div_signed", {31'd0, div_signed}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Full divide, then repeated-operand short path
        issue(C_DIVU, 32'd100, 32'd7, 5'd1, 32'd14, 35, 1'b1, t);
        check("busy_start", {31'd0, busy}, 32'd1);
        issue(C_MODU, 32'd100, 32'd7, 5'd2, 32'd2, 3, 1'b1, t);
        issue(C_DIVS, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 35, 1'b1, t);
        issue(C_MODS, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, 3, 1'b1, t);
        issue(C_DIVU, 32'd100, 32'd0, 5'd5, 32'hFFFF_FFFF, 3, 1'b1, t);
        issue(C_MODU, 32'd100, 32'd0, 5'd6, 32'd100, 3, 1'b1, t);
        wait_drain();

        // Writeback back-pressure
        @(posedge clock);
        #1 wb_ready = 1'b0;
        issue(C_DIVU, 32'd1000, 32'd10, 5'd11, 32'd100, 35, 1'b1, t);
        n = 0;
        while (!wb_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("hold_valid_seen", {31'd0, wb_valid}, 32'd1);
        repeat (5) @(negedge clock);
        check("hold_valid_still", {31'd0, wb_valid}, 32'd1);
        @(posedge clock);
        #1 wb_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("hold_release_valid", {31'd0, wb_valid}, 32'd0);
        check("hold_release_busy", {31'd0, busy}, 32'd0);

        // Flush in IDLE blocks acceptance
        @(posedge clock);
        #1;
        req_valid = 1'b1;
        flush     = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clock);
        check("flush_idle_busy", {31'd0, busy}, 32'd0);

        // Flush mid-divide, then a fresh op
        issue(C_DIVU, 32'd50, 32'd3, 5'd7, 32'd0, 0, 1'b0, t);
        wait_cyc(t + 9);
        @(posedge clock);
        #1 flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        @(negedge clock);
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_wb_valid", {31'd0, wb_valid}, 32'd0);
        s0 = start_cnt;
        issue(C_DIVU, 32'd81, 32'd9, 5'd8, 32'd9, 35, 1'b1, t);
        wait_drain();
        check("restart_pulses", start_cnt - s0, 32'd1);

        // Asynchronous reset in WAIT
        issue(C_DIVU, 32'd20, 32'd4, 5'd9, 32'd0, 0, 1'b0, t);
        wait_cyc(t + 5);
        #2 reset = 1'b1;
        #1;
        check("areset_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("areset_busy", {31'd0, busy}, 32'd0);
        check("areset_req_ready", {31'd0, req_ready}, 32'd1);
        check("areset_div_a", div_a, 32'd0);
        @(negedge clock);
        #1 reset = 1'b0;
        issue(C_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 35, 1'b1, t);
        wait_drain();

        check("scoreboard_empty", sb.size(), 32'd0);
        check("total_start_pulses", start_cnt, 32'd11);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_divide_ctrl.md
Name: cpu_divide_ctrl

Overview:
- Execute-stage sequencer that sits directly upstream of the iterative 32-bit divider (cpu_divider).
- Accepts DIVU/DIVS/MODU/MODS operations from the execute stage and registers the operands.
- Pulses the divider start, waits for done, then selects quotient or remainder.
- Holds the result on a valid/ready writeback interface; raises busy so the pipeline stalls while a divide is in flight.

Parameters:
- DEST_W, 5, width of destination register index.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  execute stage presents a divide op.
- req_ready  output  1  high only in IDLE; request accepted on edge where req_valid && req_ready && !flush.
- req_op  input  2  00 DIVU, 01 DIVS, 10 MODU, 11 MODS.
- req_a  input  32  numerator.
- req_b  input  32  denominator.
- req_dest  input  DEST_W  destination register.
- flush  input  1  pipeline kill; abandons any in-flight op.
- busy  output  1  state != IDLE.
- div_start  output  1  one-cycle start pulse to the divider.
- div_a  output  32  registered numerator.
- div_b  output  32  registered denominator.
- div_signed  output  1  registered req_op[0].
- div_quotient  input  32  divider quotient.
- div_remainder  input  32  divider remainder.
- div_done  input  1  divider done, registered level.
- wb_valid  output  1  result available.
- wb_ready  input  1  writeback accepts result.
- wb_dest  output  DEST_W  destination of result.
- wb_data  output  32  result.

Behaviour:
- Reset values: state IDLE; div_start 0; wb_valid 0; div_a, div_b, wb_data 0; wb_dest 0; div_signed 0; internal op register 00. req_ready is 1 after reset.
- FSM states: IDLE, START, WAIT, RESULT.
- IDLE, on accept: latch req_a to div_a, req_b to div_b, req_op[0] to div_signed, req_op[1] to sel_mod, req_dest to wb_dest. Go to START.
- START (exactly one cycle):
  - div_start = 1, decoded from state; no other state asserts it.
  - div_done is NOT sampled here, because it still reflects the previous operation.
  - Go to WAIT.
- WAIT:
  - On div_done = 1, capture wb_data = sel_mod ? div_remainder : div_quotient, then go to RESULT.
  - Otherwise stay in WAIT.
- RESULT:
  - wb_valid = 1, with wb_data and wb_dest stable.
  - On wb_ready, go to IDLE and drop wb_valid on that edge.
  - Back-to-back acceptance needs one IDLE cycle.
- Latency (acceptance edge = cycle T):
  - START is cycle T+1.
  - Full 32-step divide: div_done first seen high at T+34; wb_valid high from T+35.
  - Divide-by-zero or repeated-operand short path: div_done high in first WAIT cycle T+2; wb_valid from T+3.
- Arithmetic: no correction of divider results; values pass straight through.
  - Divide by zero gives quotient 0xFFFFFFFF, remainder = numerator.
  - DIVS 0x80000000 / 0xFFFFFFFF gives 0x80000000.
- Flush:
  - In any state, flush forces IDLE on the next edge and clears wb_valid. wb_data and wb_dest are retained but meaningless.
  - In IDLE, flush blocks acceptance even if req_valid is high.
  - Flush during START still lets the pulse complete; the divider result is discarded.
  - A later request re-pulses start, which restarts the divider.
- Flush and wb_ready together in RESULT: go to IDLE; the result counts as dropped.
- req_valid while not IDLE is ignored; req_ready is 0.
- Asynchronous reset mid-operation returns immediately to the reset values above. The divider is not reset; the next START overrides it.

Test Plan:
- DIVU a=100 b=7, wb_ready=1 → single wb_valid pulse at T+35 with wb_data=14, busy high T+1..T+35. Then MODU with the same operands → wb_data=2 at T+3, via the repeated-operand short path.
- DIVS a=0xFFFFFFF9 (-7) b=2 → wb_data=0xFFFFFFFD. MODS with the same operands → 0xFFFFFFFF.
- DIVU a=100 b=0 → wb_data=0xFFFFFFFF at T+3. MODU a=100 b=0 → wb_data=100.
- DIVU 1000/10 with wb_ready held low for 5 cycles after wb_valid → wb_valid, wb_data=100 and wb_dest stay stable. Returns to IDLE on the edge wb_ready rises.
- Flush at T+10 of DIVU 50/3 → IDLE at T+11 with no wb_valid. New DIVU 81/9 accepted next → div_start pulses once, wb_data=9.
- Assert reset during WAIT → wb_valid=0, busy=0, req_ready=1 immediately. A subsequent DIVS 0x80000000/0xFFFFFFFF → 0x80000000.
